// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one request at a time to imem and feeds the IF/ID register.
// Latency: accept + response latency + 1 per instruction; stallD parks one response in a buffer, which stops further requests.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallD,
   input  logic        pcsrcE,
   input  logic [31:0] pctargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instrD,
   output logic [31:0] pcD,
   output logic [31:0] pcplus4D,
   output logic        validD
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_FULL = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pcf;
   logic [31:0] reqpc;
   logic        kill;
   logic [31:0] bufinstr;
   logic [31:0] bufpc;

   logic        can_load;
   logic [31:0] reqpc_plus4;
   logic [31:0] bufpc_plus4;

   assign can_load    = !validD || !stallD;
   assign reqpc_plus4 = reqpc + 32'd4;
   assign bufpc_plus4 = bufpc + 32'd4;

   // rst gates the request directly so nothing is issued while reset is held
   assign imem_req  = (state == S_REQ) && !rst;
   assign imem_addr = pcf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_REQ;
         pcf      <= RESET_PC;
         reqpc    <= RESET_PC;
         kill     <= 1'b0;
         bufinstr <= NOP_INSTR;
         bufpc    <= 32'd0;
         instrD   <= NOP_INSTR;
         pcD      <= 32'd0;
         pcplus4D <= 32'd0;
         validD   <= 1'b0;
      end else if (pcsrcE) begin
         pcf    <= pctargetE & ~32'h3;
         validD <= 1'b0;
         instrD <= NOP_INSTR;
         case (state)
            S_REQ: begin
               // a request accepted alongside the redirect is already stale
               if (imem_ready) begin
                  reqpc <= pcf;
                  kill  <= 1'b1;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  kill  <= 1'b0;
                  state <= S_REQ;
               end else begin
                  kill <= 1'b1;
               end
            end
            default: state <= S_REQ;
         endcase
      end else begin
         // decode took the slot; later assignments override when a new instruction lands
         if (validD && !stallD) begin
            validD <= 1'b0;
            instrD <= NOP_INSTR;
         end
         case (state)
            S_REQ: begin
               if (imem_ready) begin
                  reqpc <= pcf;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (kill) begin
                     kill  <= 1'b0;
                     state <= S_REQ;
                  end else if (can_load) begin
                     instrD   <= imem_rdata;
                     pcD      <= reqpc;
                     pcplus4D <= reqpc_plus4;
                     validD   <= 1'b1;
                     pcf      <= reqpc_plus4;
                     state    <= S_REQ;
                  end else begin
                     bufinstr <= imem_rdata;
                     bufpc    <= reqpc;
                     state    <= S_FULL;
                  end
               end
            end
            S_FULL: begin
               if (can_load) begin
                  instrD   <= bufinstr;
                  pcD      <= bufpc;
                  pcplus4D <= bufpc_plus4;
                  validD   <= 1'b1;
                  pcf      <= bufpc_plus4;
                  state    <= S_REQ;
               end
            end
            default: state <= S_REQ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: transaction-level model plus a latency-programmable instruction memory.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallD = 1'b0;
   logic        pcsrcE = 1'b0;
   logic [31:0] pctargetE = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [31:0] instrD;
   logic [31:0] pcD;
   logic [31:0] pcplus4D;
   logic        validD;

   fetch_stage #(.RESET_PC(32'h00000000), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst), .stallD(stallD), .pcsrcE(pcsrcE), .pctargetE(pctargetE),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD)
   );

   always #5 clk = ~clk;

   int nchk = 0;
   int npass = 0;

   // model: next fetch pc, one outstanding transaction, one held response, IF/ID slot
   logic [31:0] m_pc, m_reqpc, m_hold_instr, m_hold_pc, m_instr, m_pcd, m_pc4;
   bit          m_busy, m_stale, m_hold, m_v;

   // memory: one pending transaction with programmable latency
   bit          mem_pend = 1'b0;
   int          mem_wait = 0;
   int          mem_lat = 1;
   logic [31:0] mem_addr = 32'd0;
   logic        s_req = 1'b0;
   logic [31:0] s_addr = 32'd0;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h00500093;
      return {a[19:0], 12'h093};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      else npass++;
   endtask

   task automatic model_reset();
      m_pc = 32'd0; m_reqpc = 32'd0; m_hold_instr = 32'd0; m_hold_pc = 32'd0;
      m_instr = NOP; m_pcd = 32'd0; m_pc4 = 32'd0;
      m_busy = 1'b0; m_stale = 1'b0; m_hold = 1'b0; m_v = 1'b0;
   endtask

   task automatic model_edge();
      bit req, slot, dlv;
      logic [31:0] di, dp;
      dlv = 1'b0; di = 32'd0; dp = 32'd0;
      if (rst) begin
         model_reset();
      end else begin
         req  = !m_busy && !m_hold;
         slot = !m_v || !stallD;
         if (pcsrcE) begin
            if (req && imem_ready) begin m_busy = 1'b1; m_stale = 1'b1; end
            else if (m_busy && imem_rvalid) m_busy = 1'b0;
            else if (m_busy) m_stale = 1'b1;
            m_hold = 1'b0;
            m_pc = pctargetE & 32'hFFFFFFFC;
            m_v = 1'b0;
            m_instr = NOP;
         end else begin
            if (req && imem_ready) begin
               m_busy = 1'b1; m_stale = 1'b0; m_reqpc = m_pc;
            end else if (m_busy && imem_rvalid) begin
               m_busy = 1'b0;
               if (!m_stale) begin
                  if (slot) begin dlv = 1'b1; di = imem_rdata; dp = m_reqpc; end
                  else begin m_hold = 1'b1; m_hold_instr = imem_rdata; m_hold_pc = m_reqpc; end
               end
            end else if (m_hold && slot) begin
               dlv = 1'b1; di = m_hold_instr; dp = m_hold_pc; m_hold = 1'b0;
            end
            if (dlv) begin
               m_v = 1'b1; m_instr = di; m_pcd = dp; m_pc4 = dp + 32'd4; m_pc = dp + 32'd4;
            end else if (m_v && !stallD) begin
               m_v = 1'b0; m_instr = NOP;
            end
         end
      end
   endtask

   task automatic mem_edge();
      if (rst) begin
         mem_pend = 1'b0;
      end else if (mem_pend) begin
         if (mem_wait == 0) mem_pend = 1'b0;
         else mem_wait--;
      end else if (s_req && imem_ready) begin
         mem_pend = 1'b1; mem_wait = mem_lat - 1; mem_addr = s_addr;
      end
   endtask

   task automatic mem_drive();
      imem_rvalid = mem_pend && (mem_wait == 0);
      imem_rdata  = imem_rvalid ? imem_word(mem_addr) : 32'hDEADBEEF;
   endtask

   task automatic compare();
      s_req  = imem_req;
      s_addr = imem_addr;
      chk("imem_req", {31'd0, imem_req}, {31'd0, !rst && !m_busy && !m_hold});
      chk("imem_addr", imem_addr, m_pc);
      chk("instrD", instrD, m_instr);
      chk("pcD", pcD, m_pcd);
      chk("pcplus4D", pcplus4D, m_pc4);
      chk("validD", {31'd0, validD}, {31'd0, m_v});
   endtask

   // one clock: apply inputs, compare at negedge, advance model and memory at posedge
   task automatic cyc(input bit st, input bit src, input logic [31:0] tgt, input bit rdy);
      stallD = st; pcsrcE = src; pctargetE = tgt; imem_ready = rdy;
      @(negedge clk);
      compare();
      @(posedge clk);
      model_edge();
      mem_edge();
      #1;
      mem_drive();
   endtask

   initial begin
      model_reset();
      @(posedge clk); #1;
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("rst_validD", {31'd0, validD}, 32'd0);
      chk("rst_instrD", instrD, NOP);
      chk("rst_pcD", pcD, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);

      rst = 1'b0; #1;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("first_instr", instrD, 32'h00500093);
      chk("first_pcD", pcD, 32'h0);
      chk("first_pc4", pcplus4D, 32'h4);
      chk("first_valid", {31'd0, validD}, 32'd1);
      chk("second_addr", imem_addr, 32'h4);

      // stall while the pc-8 response arrives
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("full_req", {31'd0, imem_req}, 32'd0);
      chk("full_pcD", pcD, 32'h4);
      cyc(1, 0, 0, 1);
      chk("full_hold_pcD", pcD, 32'h4);
      chk("full_hold_valid", {31'd0, validD}, 32'd1);
      cyc(0, 0, 0, 1);
      chk("unstall_pcD", pcD, 32'h8);
      chk("unstall_addr", imem_addr, 32'hC);

      // redirect while waiting for pc 16
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      mem_lat = 3;
      cyc(0, 0, 0, 1);
      cyc(0, 1, 32'h00000102, 1);
      chk("redir_wait_valid", {31'd0, validD}, 32'd0);
      chk("redir_wait_instr", instrD, NOP);
      chk("redir_wait_req", {31'd0, imem_req}, 32'd0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("kill_req", {31'd0, imem_req}, 32'd1);
      chk("kill_addr", imem_addr, 32'h100);
      chk("kill_valid", {31'd0, validD}, 32'd0);
      mem_lat = 1;
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("target_pcD", pcD, 32'h100);
      chk("target_instr", instrD, 32'h00100093);

      // redirect coincident with accept
      cyc(0, 1, 32'h00000200, 1);
      cyc(0, 0, 0, 1);
      chk("stale_valid", {31'd0, validD}, 32'd0);
      chk("stale_addr", imem_addr, 32'h200);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("stale_target_pcD", pcD, 32'h200);
      chk("stale_target_instr", instrD, 32'h00200093);
      chk("stale_target_pc4", pcplus4D, 32'h204);

      // redirect in REQ without accept
      cyc(0, 1, 32'h00000300, 0);
      chk("noacc_addr", imem_addr, 32'h300);
      chk("noacc_req", {31'd0, imem_req}, 32'd1);

      // redirect while a response is parked under stall
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("full2_req", {31'd0, imem_req}, 32'd0);
      cyc(1, 1, 32'h00000400, 1);
      chk("full_redir_valid", {31'd0, validD}, 32'd0);
      chk("full_redir_instr", instrD, NOP);
      chk("full_redir_addr", imem_addr, 32'h400);
      chk("full_redir_req", {31'd0, imem_req}, 32'd1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("after_full_pcD", pcD, 32'h400);

      // address wrap, with misaligned target bits dropped
      cyc(0, 1, 32'hFFFFFFFF, 0);
      chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("wrap_pcD", pcD, 32'hFFFFFFFC);
      chk("wrap_pc4", pcplus4D, 32'h0);
      chk("wrap_instr", instrD, 32'hFFFFC093);
      chk("wrap_next_addr", imem_addr, 32'h0);

      // asynchronous reset in the middle of a WAIT
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      mem_lat = 3;
      cyc(1, 0, 0, 1);
      chk("prerst_valid", {31'd0, validD}, 32'd1);
      chk("prerst_addr", imem_addr, 32'h4);
      rst = 1'b1; #1;
      chk("async_valid", {31'd0, validD}, 32'd0);
      chk("async_addr", imem_addr, 32'h0);
      chk("async_req", {31'd0, imem_req}, 32'd0);
      chk("async_instr", instrD, NOP);
      model_reset();
      mem_pend = 1'b0;
      mem_drive();
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      rst = 1'b0;
      mem_lat = 1;
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("restart_pcD", pcD, 32'h0);
      chk("restart_instr", instrD, 32'h00500093);

      // deterministic mixed pattern of stalls, redirects, ready gaps and latencies
      for (int i = 0; i < 60; i++) begin
         mem_lat = 1 + (i % 3);
         cyc((i % 5) == 3 || (i % 7) == 2, (i % 11) == 7, 32'h1000 + i * 8, (i % 3) != 1);
      end
      cyc(0, 0, 0, 1);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
